// File: rtl/matrix_issue_sequencer.sv
// Issue stage for matrix instructions: expands ld.m/st.m into per-row memory
// requests and hands gemm.m to the GEMM unit over a valid/ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | instr_ready high, decoding and accepting the next instruction
// MEM   | issuing one row request per req_ready, strided address walk
// GEMM  | holding gemm_valid with latched operands until gemm_ready
module matrix_issue_sequencer #(
  parameter int ROWS   = 4,
  parameter int ADDR_W = 32,
  parameter int MREG_W = 4
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [31:0]             instr,
  input  logic [ADDR_W-1:0]       rs1_val,
  input  logic [ADDR_W-1:0]       stride_val,
  input  logic                    flush,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic [ADDR_W-1:0]       req_addr,
  output logic [$clog2(ROWS)-1:0] req_row,
  output logic                    req_write,
  output logic [MREG_W-1:0]       req_mreg,
  output logic                    gemm_valid,
  input  logic                    gemm_ready,
  output logic [MREG_W-1:0]       gemm_md,
  output logic [MREG_W-1:0]       gemm_ma,
  output logic [MREG_W-1:0]       gemm_mb,
  output logic [MREG_W-1:0]       gemm_mc,
  output logic                    done,
  output logic                    illegal
);

  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [6:0] OP_LD   = 7'b1000111;
  localparam logic [6:0] OP_ST   = 7'b1010111;
  localparam logic [6:0] OP_GEMM = 7'b1110111;

  typedef enum logic [1:0] {IDLE, MEM, GEMM} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   stride_reg;
  logic [6:0]          opcode;
  logic [ADDR_W-1:0]   imm_sext;
  logic [MREG_W-1:0]   f_md, f_ma, f_mb, f_mc;

  assign opcode   = instr[6:0];
  assign imm_sext = ADDR_W'($signed(instr[17:7]));
  assign f_md     = instr[28 +: MREG_W];
  assign f_ma     = instr[24 +: MREG_W];
  assign f_mb     = instr[20 +: MREG_W];
  assign f_mc     = instr[16 +: MREG_W];

  // req_addr and req_row double as the address register and row counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      req_valid   <= 1'b0;
      req_addr    <= '0;
      req_row     <= '0;
      req_write   <= 1'b0;
      req_mreg    <= '0;
      stride_reg  <= '0;
      gemm_valid  <= 1'b0;
      gemm_md     <= '0;
      gemm_ma     <= '0;
      gemm_mb     <= '0;
      gemm_mc     <= '0;
      done        <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (flush) begin
        state       <= IDLE;
        instr_ready <= 1'b1;
        req_valid   <= 1'b0;
        gemm_valid  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (instr_valid) begin
              if (opcode == OP_LD || opcode == OP_ST) begin
                state       <= MEM;
                instr_ready <= 1'b0;
                req_valid   <= 1'b1;
                req_addr    <= rs1_val + imm_sext;
                stride_reg  <= stride_val;
                req_row     <= '0;
                req_write   <= (opcode == OP_ST);
                req_mreg    <= f_md;
              end else if (opcode == OP_GEMM) begin
                state       <= GEMM;
                instr_ready <= 1'b0;
                gemm_valid  <= 1'b1;
                gemm_md     <= f_md;
                gemm_ma     <= f_ma;
                gemm_mb     <= f_mb;
                gemm_mc     <= f_mc;
              end else begin
                illegal <= 1'b1;
              end
            end
          end
          MEM: begin
            if (req_ready) begin
              if (req_row == LAST_ROW) begin
                state       <= IDLE;
                instr_ready <= 1'b1;
                req_valid   <= 1'b0;
                done        <= 1'b1;
              end else begin
                req_row  <= req_row + 1'b1;
                req_addr <= req_addr + stride_reg;
              end
            end
          end
          GEMM: begin
            if (gemm_ready) begin
              state       <= IDLE;
              instr_ready <= 1'b1;
              gemm_valid  <= 1'b0;
              done        <= 1'b1;
            end
          end
          default: begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            req_valid   <= 1'b0;
            gemm_valid  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_issue_sequencer.sv
// Directed plus randomized bench for matrix_issue_sequencer; expected row
// addresses come from base + i*stride arithmetic, not from an accumulator.
module tb_matrix_issue_sequencer;

  localparam int ROWS   = 4;
  localparam int ADDR_W = 32;
  localparam int MREG_W = 4;
  localparam logic [6:0] OP_LD   = 7'b1000111;
  localparam logic [6:0] OP_ST   = 7'b1010111;
  localparam logic [6:0] OP_GEMM = 7'b1110111;

  logic                    CLK, nRST;
  logic                    instr_valid, instr_ready;
  logic [31:0]             instr;
  logic [ADDR_W-1:0]       rs1_val, stride_val;
  logic                    flush;
  logic                    req_valid, req_ready;
  logic [ADDR_W-1:0]       req_addr;
  logic [$clog2(ROWS)-1:0] req_row;
  logic                    req_write;
  logic [MREG_W-1:0]       req_mreg;
  logic                    gemm_valid, gemm_ready;
  logic [MREG_W-1:0]       gemm_md, gemm_ma, gemm_mb, gemm_mc;
  logic                    done, illegal;

  int checks = 0;
  int errors = 0;

  matrix_issue_sequencer #(.ROWS(ROWS), .ADDR_W(ADDR_W), .MREG_W(MREG_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rs1_val(rs1_val), .stride_val(stride_val), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_row(req_row), .req_write(req_write), .req_mreg(req_mreg),
    .gemm_valid(gemm_valid), .gemm_ready(gemm_ready),
    .gemm_md(gemm_md), .gemm_ma(gemm_ma), .gemm_mb(gemm_mb), .gemm_mc(gemm_mc),
    .done(done), .illegal(illegal)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_quiet(input string tag);
    chk({tag, "_req_valid"}, req_valid, 0);
    chk({tag, "_gemm_valid"}, gemm_valid, 0);
    chk({tag, "_instr_ready"}, instr_ready, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      chk_idle_quiet("idle");
      chk("idle_done", done, 0);
      chk("idle_illegal", illegal, 0);
    end
  endtask

  // mode: 0 = ready always high, 1 = ready pattern 1,0,0 repeating, 2 = random
  task automatic do_mem(input bit is_st, input logic [3:0] md, input logic [31:0] rs1,
                        input logic [31:0] stride, input logic [10:0] imm,
                        input int mode, input bit flush_after2);
    logic [31:0] base, exp_addr;
    logic        rdy;
    int i, k;
    chk("mem_accept_ready", instr_ready, 1);
    instr       = {md, 10'($urandom), imm, (is_st ? OP_ST : OP_LD)};
    rs1_val     = rs1;
    stride_val  = stride;
    instr_valid = 1'b1;
    @(negedge CLK);
    instr_valid = 1'b0;
    rs1_val     = $urandom;
    stride_val  = $urandom;
    chk("mem_first_done", done, 0);
    base = rs1 + {{21{imm[10]}}, imm};
    i = 0;
    k = 0;
    while (i < ROWS && k < 200) begin
      exp_addr = base + 32'(i) * stride;
      chk("mem_req_valid", req_valid, 1);
      chk("mem_req_addr", req_addr, exp_addr);
      chk("mem_req_row", req_row, 64'(i));
      chk("mem_req_write", req_write, is_st);
      chk("mem_req_mreg", req_mreg, md);
      chk("mem_instr_ready", instr_ready, 0);
      chk("mem_gemm_valid", gemm_valid, 0);
      if (flush_after2 && i == 2) begin
        flush     = 1'b1;
        req_ready = 1'($urandom);
        @(negedge CLK);
        flush     = 1'b0;
        req_ready = 1'b0;
        chk_idle_quiet("flush");
        chk("flush_done", done, 0);
        @(negedge CLK);
        chk_idle_quiet("flush2");
        chk("flush_done2", done, 0);
        return;
      end
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (k % 3 == 0);
      else                rdy = 1'($urandom_range(0, 1));
      req_ready = rdy;
      @(negedge CLK);
      k++;
      if (rdy) i++;
      if (i < ROWS) chk("mem_no_early_done", done, 0);
    end
    if (k >= 200) chk("mem_timeout", 0, 1);
    if (mode == 0) chk("mem_latency", 64'(k), 64'(ROWS));
    req_ready = 1'b0;
    chk("mem_done", done, 1);
    chk_idle_quiet("mem_end");
  endtask

  task automatic do_gemm(input logic [3:0] md, ma, mb, mc, input int stall);
    chk("gemm_accept_ready", instr_ready, 1);
    instr       = {md, ma, mb, mc, 9'($urandom), OP_GEMM};
    instr_valid = 1'b1;
    @(negedge CLK);
    instr_valid = 1'b0;
    chk("gemm_first_done", done, 0);
    for (int c = 0; c <= stall; c++) begin
      chk("gemm_valid", gemm_valid, 1);
      chk("gemm_md", gemm_md, md);
      chk("gemm_ma", gemm_ma, ma);
      chk("gemm_mb", gemm_mb, mb);
      chk("gemm_mc", gemm_mc, mc);
      chk("gemm_req_valid", req_valid, 0);
      chk("gemm_instr_ready", instr_ready, 0);
      if (c > 0) chk("gemm_no_early_done", done, 0);
      gemm_ready = (c == stall);
      @(negedge CLK);
    end
    gemm_ready = 1'b0;
    chk("gemm_done", done, 1);
    chk_idle_quiet("gemm_end");
  endtask

  task automatic do_illegal(input logic [6:0] op);
    chk("ill_accept_ready", instr_ready, 1);
    instr       = {25'($urandom), op};
    instr_valid = 1'b1;
    @(negedge CLK);
    instr_valid = 1'b0;
    chk("ill_pulse", illegal, 1);
    chk("ill_done", done, 0);
    chk_idle_quiet("ill");
    @(negedge CLK);
    chk("ill_pulse_end", illegal, 0);
    chk_idle_quiet("ill2");
  endtask

  initial begin
    logic [6:0] op;
    int sel;
    nRST = 1'b0; instr_valid = 1'b0; instr = '0; rs1_val = '0; stride_val = '0;
    flush = 1'b0; req_ready = 1'b0; gemm_ready = 1'b0;
    @(negedge CLK);
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_row", req_row, 0);
    chk("rst_gemm_valid", gemm_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    nRST = 1'b1;
    idle(2);

    do_mem(1'b0, 4'd3, 32'h1000, 32'h40, 11'h010, 0, 1'b0);
    idle(1);
    do_mem(1'b1, 4'd5, 32'h2000, 32'hFFFF_FFF8, 11'h7F0, 1, 1'b0);
    idle(1);
    do_gemm(4'd1, 4'd2, 4'd3, 4'd4, 3);
    do_illegal(7'b0110011);
    do_mem(1'b0, 4'd7, 32'h3000, 32'h0, 11'h004, 2, 1'b0);
    idle(1);
    do_mem(1'b0, 4'd2, 32'h4000, 32'h100, 11'h020, 0, 1'b1);
    do_gemm(4'd9, 4'd10, 4'd11, 4'd12, 0);
    idle(1);

    // flush wins over an accept in the same cycle
    instr = {4'd1, 10'd0, 11'd0, OP_LD}; instr_valid = 1'b1; flush = 1'b1;
    @(negedge CLK);
    instr_valid = 1'b0; flush = 1'b0;
    chk_idle_quiet("flush_accept");
    idle(1);

    // reset in the middle of a MEM sequence
    instr = {4'd4, 10'd0, 11'd0, OP_LD}; rs1_val = 32'h5000; stride_val = 32'h10;
    instr_valid = 1'b1; req_ready = 1'b1;
    @(negedge CLK);
    instr_valid = 1'b0;
    @(negedge CLK);
    chk("prerst_req_valid", req_valid, 1);
    #2 nRST = 1'b0;
    #1;
    chk("midrst_req_valid", req_valid, 0);
    chk("midrst_instr_ready", instr_ready, 1);
    chk("midrst_req_addr", req_addr, 0);
    @(negedge CLK);
    nRST = 1'b1;
    idle(3);
    req_ready = 1'b0;

    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0, 1: do_mem(sel[0], 4'($urandom),
                     ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom,
                     ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                     11'($urandom), 2, ($urandom_range(0, 5) == 0));
        2: do_gemm(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                   $urandom_range(0, 4));
        default: begin
          op = 7'($urandom);
          while (op == OP_LD || op == OP_ST || op == OP_GEMM) op = 7'($urandom);
          do_illegal(op);
        end
      endcase
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
